// File: rtl/cam_master_pkg.sv
// Shared CAM link definitions: framing bytes, opcodes, field offsets and FSM encoding.
package cam_master_pkg;

    localparam int unsigned MSG_LENGTH = 64;

    localparam logic [7:0] CAM_STX = 8'h02;
    localparam logic [7:0] CAM_ETX = 8'h03;

    localparam logic [7:0] OP_TEST          = 8'd0;
    localparam logic [7:0] OP_ADC_SPI       = 8'd1;
    localparam logic [7:0] OP_ADC_SYNC      = 8'd2;
    localparam logic [7:0] OP_FIFO_RST      = 8'd3;
    localparam logic [7:0] OP_ACQ_START     = 8'd4;
    localparam logic [7:0] OP_ACQ_STOP      = 8'd5;
    localparam logic [7:0] OP_PB_I2C_WR     = 8'd7;
    localparam logic [7:0] OP_SNS_I2C_RD_RS = 8'd12;
    localparam logic [7:0] OP_VERSION       = 8'd16;

    // Byte index within the packet, byte 0 is transmitted first.
    localparam int unsigned BYTE_STX    = 0;
    localparam int unsigned BYTE_OPCODE = 1;
    localparam int unsigned BYTE_ARG1   = 2;
    localparam int unsigned BYTE_ARG0   = 3;
    localparam int unsigned BYTE_PAY1   = 4;
    localparam int unsigned BYTE_PAY0   = 5;
    localparam int unsigned BYTE_CS     = 6;
    localparam int unsigned BYTE_ETX    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_LO,
        ST_TX_HI,
        ST_GAP,
        ST_RX_HI,
        ST_RX_LO,
        ST_DONE
    } cam_state_e;

    // LSB position of a packet byte inside an MSB-first shift register.
    function automatic int unsigned byte_lsb(input int unsigned idx);
        return MSG_LENGTH - 8 * (idx + 1);
    endfunction

    function automatic logic [MSG_LENGTH-1:0] build_frame(
        input logic [7:0] opcode,
        input logic [7:0] arg1,
        input logic [7:0] arg0,
        input logic [7:0] pay1,
        input logic [7:0] pay0
    );
        return {CAM_STX, opcode, arg1, arg0, pay1, pay0,
                opcode ^ arg1 ^ arg0 ^ pay1 ^ pay0, CAM_ETX};
    endfunction

endpackage

// File: rtl/cam_phase_timer.sv
// Load/count-down phase timer; done while the count sits at zero.
module cam_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cam_master.sv
// Host-side CAM 3-wire link initiator: frames a command, clocks it out, clocks back
// the response and reports payload and framing errors.
module cam_master
    import cam_master_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 50,
    parameter int unsigned TURNAROUND  = 10000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_opcode,
    input  logic [7:0] req_arg1,
    input  logic [7:0] req_arg0,
    input  logic [7:0] req_pay1,
    input  logic [7:0] req_pay0,
    output logic       rsp_valid,
    output logic [7:0] rsp_pay1,
    output logic [7:0] rsp_pay0,
    output logic [2:0] rsp_err,
    output logic       busy,
    output logic       cam_sck,
    output logic       cam_din,
    input  logic       cam_dout
);

    localparam int unsigned TMR_MAX = (HALF_PERIOD > TURNAROUND) ? HALF_PERIOD : TURNAROUND;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HP_LOAD = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] TA_LOAD = TMR_W'(TURNAROUND - 1);
    localparam logic [6:0]       BITS    = 7'(MSG_LENGTH);

    cam_state_e            state_q, state_d;
    logic [MSG_LENGTH-1:0] tx_sr, rx_sr;
    logic [6:0]            bit_cnt, bit_cnt_inc;
    logic [7:0]            opcode_q;
    logic                  dout_meta, dout_sync;
    logic                  accept;
    logic                  tmr_load, tmr_done;
    logic [TMR_W-1:0]      tmr_val;

    cam_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (state_q != ST_IDLE),
        .done     (tmr_done)
    );

    // The response cycle still counts as busy, so the next accept lands one cycle later.
    assign req_ready   = (state_q == ST_IDLE) && !rsp_valid;
    assign busy        = (state_q != ST_IDLE) || rsp_valid;
    assign accept      = req_valid && req_ready;
    assign bit_cnt_inc = bit_cnt + 7'd1;
    assign cam_sck     = (state_q == ST_TX_HI) || (state_q == ST_RX_HI);
    assign cam_din     = ((state_q == ST_TX_LO) || (state_q == ST_TX_HI)) && tx_sr[MSG_LENGTH-1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = HP_LOAD;
        unique case (state_q)
            ST_IDLE: if (accept) begin
                state_d  = ST_TX_LO;
                tmr_load = 1'b1;
            end
            ST_TX_LO: if (tmr_done) begin
                state_d  = ST_TX_HI;
                tmr_load = 1'b1;
            end
            ST_TX_HI: if (tmr_done) begin
                tmr_load = 1'b1;
                if (bit_cnt_inc == BITS) begin
                    state_d = ST_GAP;
                    tmr_val = TA_LOAD;
                end else begin
                    state_d = ST_TX_LO;
                end
            end
            ST_GAP: if (tmr_done) begin
                state_d  = ST_RX_HI;
                tmr_load = 1'b1;
            end
            ST_RX_HI: if (tmr_done) begin
                state_d  = ST_RX_LO;
                tmr_load = 1'b1;
            end
            ST_RX_LO: if (tmr_done) begin
                if (bit_cnt_inc == BITS) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_RX_HI;
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            opcode_q  <= '0;
            dout_meta <= 1'b0;
            dout_sync <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_pay1  <= '0;
            rsp_pay0  <= '0;
            rsp_err   <= '0;
        end else begin
            dout_meta <= cam_dout;
            dout_sync <= dout_meta;
            rsp_valid <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    tx_sr    <= build_frame(req_opcode, req_arg1, req_arg0, req_pay1, req_pay0);
                    opcode_q <= req_opcode;
                    bit_cnt  <= '0;
                end
                ST_TX_HI: if (tmr_done) begin
                    tx_sr   <= {tx_sr[MSG_LENGTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt_inc;
                end
                ST_GAP: if (tmr_done) begin
                    bit_cnt <= '0;
                end
                ST_RX_HI: if (tmr_done) begin
                    rx_sr <= {rx_sr[MSG_LENGTH-2:0], dout_sync};
                end
                ST_RX_LO: if (tmr_done) begin
                    bit_cnt <= bit_cnt_inc;
                end
                ST_DONE: begin
                    rsp_pay1   <= rx_sr[byte_lsb(BYTE_PAY1) +: 8];
                    rsp_pay0   <= rx_sr[byte_lsb(BYTE_PAY0) +: 8];
                    rsp_err[0] <= rx_sr[byte_lsb(BYTE_STX) +: 8] != CAM_STX;
                    rsp_err[1] <= rx_sr[byte_lsb(BYTE_ETX) +: 8] != CAM_ETX;
                    rsp_err[2] <= rx_sr[byte_lsb(BYTE_OPCODE) +: 8] != opcode_q;
                    rsp_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_master.sv
// Directed bench for cam_master paired with a behavioural CAM slave on the 3-wire link.
module tb_cam_master;

    localparam int unsigned HP  = 8;
    localparam int unsigned TA  = 40;
    localparam int unsigned LAT = 256 * HP + TA + 2;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_opcode = '0, req_arg1 = '0, req_arg0 = '0, req_pay1 = '0, req_pay0 = '0;
    logic       rsp_valid;
    logic [7:0] rsp_pay1, rsp_pay0;
    logic [2:0] rsp_err;
    logic       busy, cam_sck, cam_din;
    logic       cam_dout;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int unsigned n_acc = 0;
    int unsigned n_rsp = 0;

    cam_master #(.HALF_PERIOD(HP), .TURNAROUND(TA)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_arg1(req_arg1), .req_arg0(req_arg0),
        .req_pay1(req_pay1), .req_pay0(req_pay0),
        .rsp_valid(rsp_valid), .rsp_pay1(rsp_pay1), .rsp_pay0(rsp_pay0), .rsp_err(rsp_err),
        .busy(busy), .cam_sck(cam_sck), .cam_din(cam_din), .cam_dout(cam_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_valid && req_ready) n_acc <= n_acc + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
    end

    // Behavioural slave: samples cam_din on SCK rise, presents the response MSB first,
    // advancing one bit per SCK fall.
    logic        sck_d, s_resp, s_pend, s_fault = 1'b0;
    logic [6:0]  s_cnt;
    logic [63:0] s_cmd, s_rsp, resp_next;

    function automatic logic [63:0] make_rsp(input logic [63:0] cmd, input logic fault);
        logic [7:0] op, p1, p0;
        op = cmd[55:48];
        case (op)
            8'h00:   begin p1 = 8'hAA; p0 = 8'h55; end
            8'h10:   begin p1 = 8'h21; p0 = 8'h01; end
            default: begin p1 = ~cmd[31:24]; p0 = ~cmd[23:16]; end
        endcase
        return {8'h02, fault ? 8'h08 : op, cmd[47:32], p1, p0, 8'h00, fault ? 8'h00 : 8'h03};
    endfunction

    assign resp_next = make_rsp(s_cmd, s_fault);

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sck_d <= 1'b0; s_resp <= 1'b0; s_pend <= 1'b0; s_cnt <= '0;
            s_cmd <= '0; s_rsp <= '0; cam_dout <= 1'b0;
        end else begin
            sck_d <= cam_sck;
            if (cam_sck && !sck_d) begin
                s_cnt <= s_cnt + 7'd1;
                if (!s_resp) begin
                    s_cmd <= {s_cmd[62:0], cam_din};
                    if (s_cnt == 7'd63) s_pend <= 1'b1;
                end
            end
            if (!cam_sck && sck_d) begin
                if (s_pend) begin
                    s_pend <= 1'b0; s_resp <= 1'b1; s_cnt <= '0;
                    s_rsp <= resp_next; cam_dout <= resp_next[63];
                end else if (s_resp) begin
                    if (s_cnt == 7'd64) begin
                        s_resp <= 1'b0; s_cnt <= '0; cam_dout <= 1'b0;
                    end else begin
                        s_rsp <= {s_rsp[62:0], 1'b0}; cam_dout <= s_rsp[62];
                    end
                end
            end
        end
    end

    task automatic run_cmd(input logic [7:0] op, a1, a0, p1, p0,
                           output logic ok, output int unsigned lat);
        int unsigned t0;
        logic got;
        ok = 1'b0; lat = 0; got = 1'b0; t0 = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = op; req_arg1 = a1; req_arg0 = a0;
        req_pay1 = p1; req_pay0 = p0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready) begin t0 = cyc; got = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_opcode = 8'hFF; req_arg1 = 8'hFF; req_arg0 = 8'hFF;
        req_pay1 = 8'hFF; req_pay0 = 8'hFF;
        if (got) begin
            for (int unsigned i = 0; i < LAT + 64; i++) begin
                @(negedge clk);
                if (rsp_valid) begin lat = cyc - t0; ok = 1'b1; break; end
            end
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if ({cam_sck, cam_din} !== 2'b00) begin bad++; $display("FAIL reset_link: got %b want 00", {cam_sck, cam_din}); end
        total++; if ({rsp_pay1, rsp_pay0, rsp_err} !== 19'd0) begin bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_pay1, rsp_pay0, rsp_err}); end
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({req_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_release: got %b want 10", {req_ready, busy}); end
    endtask

    task automatic test_opcode_test;
        logic ok; int unsigned lat, n0;
        n0 = n_rsp;
        run_cmd(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, ok, lat);
        total++; if (!ok) begin bad++; $display("FAIL test_timeout: got no rsp_valid want one"); end
        total++; if ({rsp_pay1, rsp_pay0} !== 16'hAA55) begin bad++; $display("FAIL test_payload: got %h want aa55", {rsp_pay1, rsp_pay0}); end
        total++; if (rsp_err !== 3'b000) begin bad++; $display("FAIL test_err: got %b want 000", rsp_err); end
        repeat (10) @(negedge clk);
        #1;
        total++; if (n_rsp - n0 !== 1) begin bad++; $display("FAIL test_pulses: got %0d want 1", n_rsp - n0); end
        total++; if (rsp_pay1 !== 8'hAA) begin bad++; $display("FAIL test_hold: got %h want aa", rsp_pay1); end
    endtask

    task automatic test_version;
        logic ok; int unsigned lat;
        run_cmd(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, ok, lat);
        total++; if (!ok) begin bad++; $display("FAIL version_timeout: got no rsp_valid want one"); end
        total++; if ({rsp_pay1, rsp_pay0} !== 16'h2101) begin bad++; $display("FAIL version_payload: got %h want 2101", {rsp_pay1, rsp_pay0}); end
        total++; if (rsp_err !== 3'b000) begin bad++; $display("FAIL version_err: got %b want 000", rsp_err); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL version_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_frame;
        logic ok; int unsigned lat;
        run_cmd(8'h07, 8'h12, 8'h34, 8'h56, 8'h78, ok, lat);
        total++; if (!ok) begin bad++; $display("FAIL frame_timeout: got no rsp_valid want one"); end
        total++; if (s_cmd !== 64'h0207123456780F03) begin bad++; $display("FAIL frame_bits: got %h want 0207123456780f03", s_cmd); end
        total++; if ({rsp_pay1, rsp_pay0, rsp_err} !== {16'hA987, 3'b000}) begin bad++; $display("FAIL frame_rsp: got %h/%b want a987/000", {rsp_pay1, rsp_pay0}, rsp_err); end
    endtask

    task automatic test_error;
        logic ok; int unsigned lat;
        s_fault = 1'b1;
        run_cmd(8'h04, 8'h01, 8'h02, 8'hC3, 8'h3C, ok, lat);
        s_fault = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL error_timeout: got no rsp_valid want one"); end
        total++; if (rsp_err !== 3'b110) begin bad++; $display("FAIL error_flags: got %b want 110", rsp_err); end
        total++; if ({rsp_pay1, rsp_pay0} !== 16'h3CC3) begin bad++; $display("FAIL error_payload: got %h want 3cc3", {rsp_pay1, rsp_pay0}); end
    endtask

    task automatic test_reset_mid;
        logic ok, hit; int unsigned lat, n0;
        hit = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = 8'h10; req_arg1 = 8'h00; req_arg0 = 8'h00;
        req_pay1 = 8'h00; req_pay0 = 8'h00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int unsigned i = 0; i < 64 * HP; i++) begin
            @(negedge clk);
            if (!s_resp && s_cnt == 7'd20) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL midrst_reach: got no bit 20 want bit 20"); end
        n0 = n_rsp;
        #2 n_reset = 1'b0;
        #1;
        total++; if ({cam_sck, cam_din, busy} !== 3'b000) begin bad++; $display("FAIL midrst_outputs: got %b want 000", {cam_sck, cam_din, busy}); end
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        total++; if (n_rsp !== n0) begin bad++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", n_rsp - n0); end
        run_cmd(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, ok, lat);
        total++; if (!ok || rsp_err !== 3'b000 || {rsp_pay1, rsp_pay0} !== 16'h2101) begin
            bad++; $display("FAIL midrst_recover: got ok=%b err=%b pay=%h want 1/000/2101", ok, rsp_err, {rsp_pay1, rsp_pay0});
        end
    endtask

    task automatic test_back_to_back;
        int unsigned a0, r1, r2;
        logic got1, got2;
        got1 = 1'b0; got2 = 1'b0; r1 = 0; r2 = 0;
        a0 = n_acc;
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = 8'h00; req_arg1 = 8'h00; req_arg0 = 8'h00;
        req_pay1 = 8'h00; req_pay0 = 8'h00;
        for (int unsigned i = 0; i < LAT + 64; i++) begin
            @(negedge clk);
            if (rsp_valid) begin r1 = cyc; got1 = 1'b1; break; end
        end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_at_rsp: got %b want 0", req_ready); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after: got %b want 1", req_ready); end
        for (int unsigned i = 0; i < LAT + 64; i++) begin
            @(negedge clk);
            if (rsp_valid) begin r2 = cyc; got2 = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        total++; if (!(got1 && got2)) begin bad++; $display("FAIL b2b_timeout: got %b%b want 11", got1, got2); end
        total++; if (r2 - r1 !== LAT + 1) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", r2 - r1, LAT + 1); end
        total++; if (n_acc - a0 !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", n_acc - a0); end
    endtask

    initial begin
        test_reset();
        test_opcode_test();
        test_version();
        test_frame();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
